data_tlb_check: RTL and testbench
=================================

# data_tlb_check

Post-lookup check stage for the data-side address translation path. It accepts a load/store request, drives the TLB search strobe, and samples the TLB results returned one cycle later. It then checks alignment, TLB refill, invalid, privilege and modify conditions, and presents the physical address with an exception verdict to the data cache / MEM stage. A two-deep pipeline with a result capture register lets it sustain one request per cycle under downstream back-pressure.

## Interface
Parameters:
- CNT_W, 16, width of the saturating TLB-refill event counter

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  discard all in-flight requests
- s_valid  in  1  request valid
- s_ready  out  1  request accepted when s_valid && s_ready
- s_vaddr  in  32  virtual address
- s_op  in  1  0 = load, 1 = store
- s_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved (treated as word)
- s_trans_en  in  1  page translation in effect for this request
- s_direct_tag  in  20  physical tag when s_trans_en = 0 (DMW or direct mode)
- s_direct_mat  in  2  memory access type when s_trans_en = 0
- csr_plv  in  2  current privilege level
- tlb_fetch  out  1  search strobe to translation unit; equals s_valid && s_ready
- tlb_found, tlb_v, tlb_d  in  1 each  lookup result, valid the cycle after tlb_fetch
- tlb_mat, tlb_plv  in  2 each  lookup result
- tlb_index  in  5  hit entry index
- tlb_tag  in  20  translated physical tag
- m_valid  out  1  result valid
- m_ready  in  1  consumer accepts
- m_paddr  out  32  physical address, {tag, vaddr[11:0]}
- m_mat  out  2  memory access type
- m_exc  out  1  exception flag
- m_ecode  out  6  exception code
- m_badv  out  32  faulting virtual address (equals vaddr)
- m_tlb_index  out  5  hit index, for debug and TLBSRCH reuse
- refill_cnt  out  CNT_W  saturating count of TLBR results delivered

## Operation
- Stage A holds the accepted request: vaddr, op, size, trans_en, direct tag and direct MAT. A `fresh` flag is set on acceptance.
- While `fresh` = 1, the stage uses the live tlb_* inputs. At the end of A's first resident cycle, all tlb_* inputs are captured into A and `fresh` is cleared. A stalled request therefore keeps a correct result.
- Advance rules:
  - A advances to stage B (the output register) when !m_valid || m_ready.
  - s_ready = !a_valid || a_advance.
- Exceptions, highest priority first; only the first match is reported:
  - ALE 6'h09: the address is misaligned. Half requires vaddr[0] = 0. Word and reserved require vaddr[1:0] = 0.
  - TLBR 6'h3F: trans_en && !found.
  - PIL 6'h01 (load) or PIS 6'h02 (store): trans_en && found && !v.
  - PPI 6'h07: trans_en && csr_plv > tlb_plv. csr_plv is sampled at the A→B transfer.
  - PME 6'h04: trans_en && store && !d.
  - Otherwise m_exc = 0 and m_ecode = 0.
- Address and MAT selection:
  - m_paddr = {trans_en ? tlb_tag : direct_tag, vaddr[11:0]}.
  - m_mat = trans_en ? tlb_mat : direct_mat.
  - m_paddr and m_mat are formed even when an exception is reported.
- refill_cnt increments on every m_valid && m_ready carrying TLBR. It holds at all-ones.
- Flush:
  - Clears a_valid and m_valid at the next edge.
  - Forces s_ready = 0 in the flush cycle, so no acceptance and no tlb_fetch occur then.
  - refill_cnt is unaffected.

## Timing
- Reset values:
  - a_valid, m_valid = 0.
  - m_paddr, m_badv, m_ecode, m_mat, m_tlb_index, m_exc = 0.
  - refill_cnt = 0.
  - s_ready = 1 after reset, unless flush is asserted.
- Latency: request accepted at edge N (cycle N) → m_valid high in cycle N+2 when unstalled.
- Throughput: one request per cycle with m_ready held high.
- Output stability: while m_valid && !m_ready, all m_* outputs are held stable.
- Back-pressure:
  - With B full and m_ready = 0, at most one further request is accepted into A. s_ready then drops.
  - When m_ready rises, A moves into B on that edge and a new request is accepted on the same edge.
- Simultaneous flush and m_ready: flush wins, and the delivered beat does not count toward refill_cnt.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.

## Test plan
- Back-to-back loads, trans_en = 1, found/v = 1, tlb_tag = 20'h12345, vaddr = 32'h0000_0ABC aligned word (size 2 requires vaddr[1:0] = 0), m_ready = 1 → m_paddr = 32'h12345ABC, m_exc = 0, one result per cycle, first result in cycle N+2.
- Store with found = 1, v = 1, d = 0, csr_plv = 0, tlb_plv = 0 → m_ecode = 6'h04. Repeat with csr_plv = 3, tlb_plv = 0 → m_ecode = 6'h07, confirming PPI outranks PME.
- Half-word load at vaddr 32'h1001 with found = 0 → m_ecode = 6'h09, m_badv = 32'h1001, refill_cnt unchanged. Same request at vaddr 32'h1000 → m_ecode = 6'h3F and refill_cnt increments by 1.
- Hold m_ready = 0 for 5 cycles with two requests accepted, and change the tlb_* inputs after the capture cycle → s_ready = 0 after the second acceptance, and both results carry the originally captured tags, in order.
- trans_en = 0, s_direct_tag = 20'hA0000, s_direct_mat = 2'b01, tlb_found = 0 → m_paddr = {20'hA0000, vaddr[11:0]}, m_mat = 2'b01, m_exc = 0.
- Assert flush with A and B full, then drive rst_n low mid-stream. Expected sequence:
  - Flush: m_valid = 0 next cycle, no tlb_fetch in the flush cycle.
  - Reset: all outputs zero immediately, refill_cnt = 0.
  - Force refill_cnt to all-ones and deliver a further TLBR → the count stays all-ones.

Source files
------------

// File: rtl/data_tlb_check.sv
// Data-side post-TLB-lookup check stage: holds a request in stage A while the TLB answers,
// classifies alignment/TLB/privilege faults and registers the verdict in the output stage B.
module data_tlb_check #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_vaddr,
    input  logic             s_op,
    input  logic [1:0]       s_size,
    input  logic             s_trans_en,
    input  logic [19:0]      s_direct_tag,
    input  logic [1:0]       s_direct_mat,
    input  logic [1:0]       csr_plv,
    output logic             tlb_fetch,
    input  logic             tlb_found,
    input  logic             tlb_v,
    input  logic             tlb_d,
    input  logic [1:0]       tlb_mat,
    input  logic [1:0]       tlb_plv,
    input  logic [4:0]       tlb_index,
    input  logic [19:0]      tlb_tag,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [31:0]      m_paddr,
    output logic [1:0]       m_mat,
    output logic             m_exc,
    output logic [5:0]       m_ecode,
    output logic [31:0]      m_badv,
    output logic [4:0]       m_tlb_index,
    output logic [CNT_W-1:0] refill_cnt
);
    typedef struct packed {
        logic        found;
        logic        v;
        logic        d;
        logic [1:0]  mat;
        logic [1:0]  plv;
        logic [4:0]  index;
        logic [19:0] tag;
    } tlb_res_t;

    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_TLBR = 6'h3F;
    localparam logic [5:0] ECODE_PIL  = 6'h01;
    localparam logic [5:0] ECODE_PIS  = 6'h02;
    localparam logic [5:0] ECODE_PPI  = 6'h07;
    localparam logic [5:0] ECODE_PME  = 6'h04;

    // Stage A
    logic        a_valid_q, a_valid_d;
    logic        a_fresh_q, a_fresh_d;
    logic [31:0] a_vaddr_q, a_vaddr_d;
    logic        a_op_q, a_op_d;
    logic [1:0]  a_size_q, a_size_d;
    logic        a_trans_en_q, a_trans_en_d;
    logic [19:0] a_dtag_q, a_dtag_d;
    logic [1:0]  a_dmat_q, a_dmat_d;
    tlb_res_t    a_tlb_q, a_tlb_d;

    // Stage B (output register)
    logic             m_valid_q, m_valid_d;
    logic [31:0]      m_paddr_q, m_paddr_d;
    logic [1:0]       m_mat_q, m_mat_d;
    logic             m_exc_q, m_exc_d;
    logic [5:0]       m_ecode_q, m_ecode_d;
    logic [31:0]      m_badv_q, m_badv_d;
    logic [4:0]       m_tlb_index_q, m_tlb_index_d;
    logic [CNT_W-1:0] refill_cnt_q, refill_cnt_d;

    tlb_res_t tlb_live, tlb_eff;
    logic     a_advance, accept, misaligned, exc_c;
    logic [5:0] ecode_c;

    assign tlb_live = '{found: tlb_found, v: tlb_v, d: tlb_d, mat: tlb_mat,
                        plv: tlb_plv, index: tlb_index, tag: tlb_tag};
    // Live lookup data is only valid in A's first resident cycle; afterwards use the captured copy.
    assign tlb_eff   = a_fresh_q ? tlb_live : a_tlb_q;
    assign a_advance = a_valid_q && (!m_valid_q || m_ready) && !flush;
    assign s_ready   = !flush && (!a_valid_q || a_advance);
    assign accept    = s_valid && s_ready;
    assign tlb_fetch = accept;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        misaligned = 1'b0;
        exc_c      = 1'b1;
        ecode_c    = '0;
        case (a_size_q)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = a_vaddr_q[0];
            default: misaligned = |a_vaddr_q[1:0];
        endcase
        if (misaligned)                                   ecode_c = ECODE_ALE;
        else if (a_trans_en_q && !tlb_eff.found)          ecode_c = ECODE_TLBR;
        else if (a_trans_en_q && !tlb_eff.v)              ecode_c = a_op_q ? ECODE_PIS : ECODE_PIL;
        else if (a_trans_en_q && (csr_plv > tlb_eff.plv)) ecode_c = ECODE_PPI;
        else if (a_trans_en_q && a_op_q && !tlb_eff.d)    ecode_c = ECODE_PME;
        else                                              exc_c   = 1'b0;
    end

    always_comb begin
        a_valid_d    = a_valid_q;
        a_fresh_d    = a_fresh_q;
        a_vaddr_d    = a_vaddr_q;
        a_op_d       = a_op_q;
        a_size_d     = a_size_q;
        a_trans_en_d = a_trans_en_q;
        a_dtag_d     = a_dtag_q;
        a_dmat_d     = a_dmat_q;
        a_tlb_d      = a_tlb_q;
        if (a_fresh_q) begin
            a_tlb_d   = tlb_live;
            a_fresh_d = 1'b0;
        end
        if (flush) begin
            a_valid_d = 1'b0;
        end else if (accept) begin
            a_valid_d    = 1'b1;
            a_fresh_d    = 1'b1;
            a_vaddr_d    = s_vaddr;
            a_op_d       = s_op;
            a_size_d     = s_size;
            a_trans_en_d = s_trans_en;
            a_dtag_d     = s_direct_tag;
            a_dmat_d     = s_direct_mat;
        end else if (a_advance) begin
            a_valid_d = 1'b0;
        end
    end

    always_comb begin
        m_valid_d     = m_valid_q;
        m_paddr_d     = m_paddr_q;
        m_mat_d       = m_mat_q;
        m_exc_d       = m_exc_q;
        m_ecode_d     = m_ecode_q;
        m_badv_d      = m_badv_q;
        m_tlb_index_d = m_tlb_index_q;
        refill_cnt_d  = refill_cnt_q;
        if (flush) begin
            m_valid_d = 1'b0;
        end else begin
            if (m_valid_q && m_ready && m_exc_q && (m_ecode_q == ECODE_TLBR) && (refill_cnt_q != '1))
                refill_cnt_d = refill_cnt_q + CNT_W'(1);
            if (a_advance) begin
                m_valid_d     = 1'b1;
                m_paddr_d     = {a_trans_en_q ? tlb_eff.tag : a_dtag_q, a_vaddr_q[11:0]};
                m_mat_d       = a_trans_en_q ? tlb_eff.mat : a_dmat_q;
                m_exc_d       = exc_c;
                m_ecode_d     = ecode_c;
                m_badv_d      = a_vaddr_q;
                m_tlb_index_d = tlb_eff.index;
            end else if (m_ready) begin
                m_valid_d = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid_q     <= 1'b0;
            a_fresh_q     <= 1'b0;
            a_vaddr_q     <= '0;
            a_op_q        <= 1'b0;
            a_size_q      <= '0;
            a_trans_en_q  <= 1'b0;
            a_dtag_q      <= '0;
            a_dmat_q      <= '0;
            a_tlb_q       <= '0;
            m_valid_q     <= 1'b0;
            m_paddr_q     <= '0;
            m_mat_q       <= '0;
            m_exc_q       <= 1'b0;
            m_ecode_q     <= '0;
            m_badv_q      <= '0;
            m_tlb_index_q <= '0;
            refill_cnt_q  <= '0;
        end else begin
            a_valid_q     <= a_valid_d;
            a_fresh_q     <= a_fresh_d;
            a_vaddr_q     <= a_vaddr_d;
            a_op_q        <= a_op_d;
            a_size_q      <= a_size_d;
            a_trans_en_q  <= a_trans_en_d;
            a_dtag_q      <= a_dtag_d;
            a_dmat_q      <= a_dmat_d;
            a_tlb_q       <= a_tlb_d;
            m_valid_q     <= m_valid_d;
            m_paddr_q     <= m_paddr_d;
            m_mat_q       <= m_mat_d;
            m_exc_q       <= m_exc_d;
            m_ecode_q     <= m_ecode_d;
            m_badv_q      <= m_badv_d;
            m_tlb_index_q <= m_tlb_index_d;
            refill_cnt_q  <= refill_cnt_d;
        end
    end

    assign m_valid     = m_valid_q;
    assign m_paddr     = m_paddr_q;
    assign m_mat       = m_mat_q;
    assign m_exc       = m_exc_q;
    assign m_ecode     = m_ecode_q;
    assign m_badv      = m_badv_q;
    assign m_tlb_index = m_tlb_index_q;
    assign refill_cnt  = refill_cnt_q;

endmodule

// File: tb/tb_data_tlb_check.sv
// Directed bench for data_tlb_check: a transaction-level model predicts every delivered result,
// s_ready and the refill count, while directed steps pin literal values.
module tb_data_tlb_check;
    localparam int CNT_W = 4;
    localparam int unsigned REFILL_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n, flush, s_valid, s_ready, s_op, s_trans_en;
    logic [31:0]      s_vaddr;
    logic [1:0]       s_size, s_direct_mat, csr_plv;
    logic [19:0]      s_direct_tag;
    logic             tlb_fetch, tlb_found, tlb_v, tlb_d;
    logic [1:0]       tlb_mat, tlb_plv;
    logic [4:0]       tlb_index;
    logic [19:0]      tlb_tag;
    logic             m_valid, m_ready, m_exc;
    logic [31:0]      m_paddr, m_badv;
    logic [1:0]       m_mat;
    logic [5:0]       m_ecode;
    logic [4:0]       m_tlb_index;
    logic [CNT_W-1:0] refill_cnt;

    data_tlb_check #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_vaddr(s_vaddr), .s_op(s_op), .s_size(s_size),
        .s_trans_en(s_trans_en), .s_direct_tag(s_direct_tag), .s_direct_mat(s_direct_mat),
        .csr_plv(csr_plv), .tlb_fetch(tlb_fetch),
        .tlb_found(tlb_found), .tlb_v(tlb_v), .tlb_d(tlb_d), .tlb_mat(tlb_mat), .tlb_plv(tlb_plv),
        .tlb_index(tlb_index), .tlb_tag(tlb_tag),
        .m_valid(m_valid), .m_ready(m_ready), .m_paddr(m_paddr), .m_mat(m_mat), .m_exc(m_exc),
        .m_ecode(m_ecode), .m_badv(m_badv), .m_tlb_index(m_tlb_index), .refill_cnt(refill_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        logic [31:0] vaddr;
        logic        op;
        logic [1:0]  size;
        logic        te;
        logic [19:0] dtag;
        logic [1:0]  dmat;
    } req_t;

    typedef struct {
        logic [31:0] paddr;
        logic [1:0]  mat;
        logic        exc;
        logic [5:0]  ecode;
        logic [31:0] badv;
        logic [4:0]  idx;
    } res_t;

    res_t        outq[$];
    req_t        pend;
    bit          pend_v = 0;
    int unsigned exp_refill = 0;

    function automatic res_t predict(input req_t r, input logic found, input logic v, input logic d,
                                     input logic [1:0] mat, input logic [1:0] plv,
                                     input logic [4:0] idx, input logic [19:0] tag,
                                     input logic [1:0] cur_plv);
        res_t o;
        int   bytes;
        bytes   = (r.size == 2'd0) ? 1 : (r.size == 2'd1) ? 2 : 4;
        o.paddr = {r.te ? tag : r.dtag, r.vaddr[11:0]};
        o.mat   = r.te ? mat : r.dmat;
        o.badv  = r.vaddr;
        o.idx   = idx;
        o.exc   = 1'b1;
        if ((r.vaddr % bytes) != 0)             o.ecode = 6'h09;
        else if (r.te && !found)                o.ecode = 6'h3F;
        else if (r.te && !v)                    o.ecode = r.op ? 6'h02 : 6'h01;
        else if (r.te && (cur_plv > plv))       o.ecode = 6'h07;
        else if (r.te && r.op && !d)            o.ecode = 6'h04;
        else begin o.exc = 1'b0; o.ecode = 6'h00; end
        return o;
    endfunction

    always @(posedge clk) begin
        res_t r;
        if (!rst_n) begin
            outq.delete();
            pend_v     = 0;
            exp_refill = 0;
        end else if (flush) begin
            outq.delete();
            pend_v = 0;
        end else begin
            if (m_valid && m_ready && outq.size() > 0) begin
                r = outq.pop_front();
                if (r.exc && r.ecode == 6'h3F && exp_refill < REFILL_MAX) exp_refill++;
            end
            if (pend_v) begin
                outq.push_back(predict(pend, tlb_found, tlb_v, tlb_d, tlb_mat, tlb_plv,
                                       tlb_index, tlb_tag, csr_plv));
                pend_v = 0;
            end
            if (s_valid && s_ready) begin
                pend   = '{vaddr: s_vaddr, op: s_op, size: s_size, te: s_trans_en,
                           dtag: s_direct_tag, dmat: s_direct_mat};
                pend_v = 1;
            end
        end
    end

    // Compare process: runs every cycle outside reset.
    always @(negedge clk) begin
        int   inflight;
        logic exp_rdy;
        res_t e;
        if (rst_n) begin
            inflight = outq.size() + (pend_v ? 1 : 0);
            exp_rdy  = !flush && (inflight < 2 || m_ready);
            check("s_ready", s_ready, exp_rdy);
            check("tlb_fetch", tlb_fetch, s_valid && exp_rdy);
            check("refill_cnt", refill_cnt, exp_refill);
            if (m_valid) begin
                check("beat_has_model", outq.size() > 0, 1);
                if (outq.size() > 0) begin
                    e = outq[0];
                    check("m_paddr", m_paddr, e.paddr);
                    check("m_mat", m_mat, e.mat);
                    check("m_exc", m_exc, e.exc);
                    check("m_ecode", m_ecode, e.ecode);
                    check("m_badv", m_badv, e.badv);
                    check("m_tlb_index", m_tlb_index, e.idx);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [31:0] va, input logic op, input logic [1:0] sz, input logic te);
        s_vaddr = va; s_op = op; s_size = sz; s_trans_en = te;
    endtask

    task automatic set_tlb(input logic found, input logic v, input logic d, input logic [1:0] mat,
                           input logic [1:0] plv, input logic [4:0] idx, input logic [19:0] tag);
        tlb_found = found; tlb_v = v; tlb_d = d; tlb_mat = mat;
        tlb_plv = plv; tlb_index = idx; tlb_tag = tag;
    endtask

    // Presents one request from an idle pipe and stops at the negedge where its result is visible.
    task automatic send_wait(input string name);
        s_valid = 1'b1;
        check({name, "_acc"}, s_ready, 1);
        tick();
        s_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (m_valid) break;
        end
        check({name, "_mvalid"}, m_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b1; csr_plv = 2'd0;
        s_direct_tag = '0; s_direct_mat = '0;
        set_req(32'h0, 1'b0, 2'd2, 1'b1);
        set_tlb(1'b1, 1'b1, 1'b1, 2'd1, 2'd3, 5'd5, 20'h12345);
        #2;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_paddr", m_paddr, 0);
        check("rst_m_ecode", m_ecode, 0);
        check("rst_refill", refill_cnt, 0);
        tick(); tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_s_ready", s_ready, 1);
        tick();

        // Back-to-back aligned word loads, first result two edges after acceptance.
        set_req(32'h0000_0ABC, 1'b0, 2'd2, 1'b1);
        s_valid = 1'b1;
        tick();
        set_req(32'h7777_7AB0, 1'b0, 2'd2, 1'b1);
        @(negedge clk); check("lat_early", m_valid, 0);
        tick();
        set_req(32'h0000_0FFC, 1'b0, 2'd2, 1'b1);
        @(negedge clk);
        check("b2b_v0", m_valid, 1);
        check("b2b_p0", m_paddr, 32'h1234_5ABC);
        check("b2b_e0", m_exc, 0);
        check("b2b_idx", m_tlb_index, 5'd5);
        check("b2b_mat", m_mat, 2'd1);
        tick();
        s_valid = 1'b0;
        @(negedge clk); check("b2b_p1", m_paddr, 32'h1234_5AB0);
        tick();
        @(negedge clk); check("b2b_p2", m_paddr, 32'h1234_5FFC);
        tick();
        @(negedge clk); check("b2b_drain", m_valid, 0);
        tick();

        // Store to clean page: PME, then PPI outranks PME.
        set_tlb(1'b1, 1'b1, 1'b0, 2'd1, 2'd0, 5'd3, 20'h0BEEF);
        set_req(32'h0000_2000, 1'b1, 2'd2, 1'b1);
        csr_plv = 2'd0;
        send_wait("pme");
        check("pme_code", m_ecode, 6'h04);
        check("pme_exc", m_exc, 1);
        check("pme_paddr", m_paddr, 32'h0BEE_F000);
        tick();
        csr_plv = 2'd3;
        send_wait("ppi");
        check("ppi_code", m_ecode, 6'h07);
        tick();
        csr_plv = 2'd0;

        // Misaligned half beats TLBR; aligned half gives TLBR and counts.
        set_tlb(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd0, 20'h00042);
        set_req(32'h0000_1001, 1'b0, 2'd1, 1'b1);
        send_wait("ale");
        check("ale_code", m_ecode, 6'h09);
        check("ale_badv", m_badv, 32'h0000_1001);
        tick();
        check("ale_refill", refill_cnt, 0);
        set_req(32'h0000_1000, 1'b0, 2'd1, 1'b1);
        send_wait("tlbr");
        check("tlbr_code", m_ecode, 6'h3F);
        tick();
        check("tlbr_refill", refill_cnt, 1);

        // Back-pressure with lookup data changing after each capture cycle.
        m_ready = 1'b0;
        set_tlb(1'b1, 1'b1, 1'b1, 2'd2, 2'd3, 5'd7, 20'h11111);
        set_req(32'h0000_0100, 1'b0, 2'd2, 1'b1);
        s_valid = 1'b1;
        tick();
        set_req(32'h0000_0200, 1'b0, 2'd2, 1'b1);
        tick();
        tlb_tag = 20'h22222;
        set_req(32'h0000_0300, 1'b0, 2'd2, 1'b1);
        @(negedge clk); check("stall_sready0", s_ready, 0);
        tick();
        tlb_tag = 20'h33333;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_sready", s_ready, 0);
            check("stall_hold", m_paddr, 32'h1111_1100);
            tick();
        end
        m_ready = 1'b1;
        @(negedge clk);
        check("unstall_sready", s_ready, 1);
        check("unstall_p0", m_paddr, 32'h1111_1100);
        tick();
        s_valid = 1'b0;
        @(negedge clk); check("unstall_p1", m_paddr, 32'h2222_2200);
        tick();
        @(negedge clk); check("unstall_p2", m_paddr, 32'h3333_3300);
        tick(); tick();

        // Direct (untranslated) byte access.
        set_tlb(1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 5'd1, 20'h55555);
        s_direct_tag = 20'hA0000; s_direct_mat = 2'b01;
        set_req(32'h0000_0567, 1'b0, 2'd0, 1'b0);
        send_wait("direct");
        check("direct_paddr", m_paddr, 32'hA000_0567);
        check("direct_mat", m_mat, 2'b01);
        check("direct_exc", m_exc, 0);
        tick();
        s_direct_tag = '0; s_direct_mat = '0;

        // Flush with A and B full of TLBR results while the consumer accepts.
        m_ready = 1'b0;
        set_tlb(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd0, 20'h0DEAD);
        set_req(32'h0000_3000, 1'b0, 2'd2, 1'b1);
        s_valid = 1'b1;
        tick();
        set_req(32'h0000_3004, 1'b0, 2'd2, 1'b1);
        tick();
        tick();
        flush = 1'b1; m_ready = 1'b1;
        @(negedge clk);
        check("flush_sready", s_ready, 0);
        check("flush_fetch", tlb_fetch, 0);
        check("flush_mvalid_before", m_valid, 1);
        tick();
        flush = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        check("flush_mvalid", m_valid, 0);
        check("flush_refill", refill_cnt, 1);
        tick(); tick();

        // Asynchronous reset while a result is stalled in B.
        m_ready = 1'b0;
        set_tlb(1'b1, 1'b1, 1'b1, 2'd2, 2'd3, 5'd9, 20'h0CAFE);
        set_req(32'h0000_4008, 1'b0, 2'd2, 1'b1);
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        tick(); tick();
        @(negedge clk);
        check("pre_rst_paddr", m_paddr, 32'h0CAF_E008);
        #2 rst_n = 1'b0;
        #1;
        check("arst_m_valid", m_valid, 0);
        check("arst_m_paddr", m_paddr, 0);
        check("arst_m_badv", m_badv, 0);
        check("arst_m_exc", m_exc, 0);
        check("arst_idx", m_tlb_index, 0);
        check("arst_refill", refill_cnt, 0);
        tick();
        rst_n = 1'b1; m_ready = 1'b1;
        tick();

        // Saturation of the refill counter.
        set_tlb(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd2, 20'h0F00D);
        set_req(32'h0000_5000, 1'b0, 2'd2, 1'b1);
        s_valid = 1'b1;
        repeat (REFILL_MAX) tick();
        s_valid = 1'b0;
        repeat (4) tick();
        check("sat_reach", refill_cnt, REFILL_MAX);
        send_wait("sat");
        tick();
        check("sat_hold", refill_cnt, REFILL_MAX);
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
